// File: rtl/sram_b_pkg.sv
// Shared types for the sram_b burst reader: FSM states, FIFO entry layout and
// default geometry.
package sram_b_pkg;

    localparam int ABITS_DEF      = 20;
    localparam int DBITS_DEF      = 8;
    localparam int LBITS_DEF      = 20;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // FIFO words are packed as {last, data}; last sits in the MSB.
    typedef struct packed {
        logic                 last;
        logic [DBITS_DEF-1:0] data;
    } fifo_entry_t;

    function automatic int fifo_count_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram_b_burst_reader_if.sv
// Command, SRAM read-port and output-stream signals of the burst reader.
// master = the reader itself, slave = whoever drives it and owns the SRAM.
interface sram_b_burst_reader_if #(
    parameter int ABITS = 20,
    parameter int DBITS = 8,
    parameter int LBITS = 20
) ();
    logic             req_valid;
    logic             req_ready;
    logic [ABITS-1:0] req_addr;
    logic [LBITS-1:0] req_len;

    logic             CE1;
    logic [ABITS-1:0] A1;
    logic [DBITS-1:0] Q1;

    logic             out_valid;
    logic             out_ready;
    logic [DBITS-1:0] out_data;
    logic             out_last;

    modport master (
        input  req_valid, req_addr, req_len, Q1, out_ready,
        output req_ready, CE1, A1, out_valid, out_data, out_last
    );

    modport slave (
        output req_valid, req_addr, req_len, Q1, out_ready,
        input  req_ready, CE1, A1, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sram_b_sync_fifo.sv
// Small first-word-fall-through FIFO with reset storage, so the head never
// shows X even before the first push.
module sram_b_sync_fifo
    import sram_b_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = fifo_count_bits(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count_reg != '0);
    assign do_push = push & ((count_reg != CW'(DEPTH)) | do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

endmodule

// File: rtl/sram_b_burst_reader.sv
// Burst read initiator for the sram_b read port: one read per cycle while the
// output FIFO has credit, data returned as a valid/ready stream with last flag.
module sram_b_burst_reader
    import sram_b_pkg::*;
#(
    parameter int ABITS      = ABITS_DEF,
    parameter int DBITS      = DBITS_DEF,
    parameter int LBITS      = LBITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    sram_b_burst_reader_if.master bus,
    output logic                  busy
);
    localparam int CW = fifo_count_bits(FIFO_DEPTH);

    state_t           state_reg;
    state_t           state_next;
    logic [ABITS-1:0] cur_addr_reg;
    logic [LBITS-1:0] remaining_reg;
    logic             inflight_reg;
    logic             tag_reg;

    logic             credit;
    logic             accept;
    logic             issue;
    logic [CW:0]      occupancy;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [DBITS:0]   fifo_head;

    // Credit ignores a same-cycle pop, so a push can never land on a full FIFO.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
    assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.req_valid) state_next = ISSUE;
            ISSUE:   if (credit && (remaining_reg == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.CE1       = 1'b0;
        case (state_reg)
            IDLE:    bus.req_ready = 1'b1;
            ISSUE:   bus.CE1       = credit;
            default: ;
        endcase
    end

    assign accept = bus.req_valid & bus.req_ready;
    assign issue  = bus.CE1;
    assign bus.A1 = cur_addr_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            inflight_reg  <= 1'b0;
            tag_reg       <= 1'b0;
        end else begin
            if (accept) begin
                cur_addr_reg  <= bus.req_addr;
                remaining_reg <= bus.req_len;
            end else if (issue) begin
                cur_addr_reg  <= cur_addr_reg + ABITS'(1);
                remaining_reg <= remaining_reg - LBITS'(1);
            end
            // The tag travels with the read so it meets Q1 one cycle later.
            inflight_reg <= issue;
            if (issue) tag_reg <= (remaining_reg == '0);
        end
    end

    sram_b_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DBITS + 1)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (inflight_reg),
        .push_data ({tag_reg, bus.Q1}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign bus.out_valid = ~fifo_empty;
    assign fifo_pop      = bus.out_valid & bus.out_ready;
    assign bus.out_last  = fifo_head[DBITS];
    assign bus.out_data  = fifo_head[DBITS-1:0];

    assign busy = (state_reg != IDLE) | inflight_reg | ~fifo_empty;

endmodule

// File: tb/tb_sram_b_burst_reader.sv
// Self-checking bench for sram_b_burst_reader: directed table, hand-written
// corner sequences and randomized bursts against a beat-list reference model.
module tb_sram_b_burst_reader;
    import sram_b_pkg::*;

    localparam int ABITS = 20;
    localparam int DBITS = 8;
    localparam int LBITS = 20;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RST;
    logic busy;

    sram_b_burst_reader_if #(.ABITS(ABITS), .DBITS(DBITS), .LBITS(LBITS)) bus ();

    sram_b_burst_reader #(
        .ABITS      (ABITS),
        .DBITS      (DBITS),
        .LBITS      (LBITS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .busy (busy)
    );

    always #5 CLK = ~CLK;

    // Preloaded memory contents expressed as a function of the address.
    function automatic logic [DBITS-1:0] mem_word(input logic [ABITS-1:0] a);
        logic [31:0] x;
        x = {12'd0, a} * 32'd2654435761;
        return x[23:16] ^ a[7:0];
    endfunction

    // SRAM read port model: Q1 valid the cycle after CE1.
    always @(posedge CLK) begin
        if (bus.CE1) bus.Q1 <= mem_word(bus.A1);
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [ABITS-1:0] iss_addr_q[$];
    int               iss_cyc_q[$];
    fifo_entry_t      beat_q[$];
    int               beat_cyc_q[$];

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.CE1) begin
                iss_addr_q.push_back(bus.A1);
                iss_cyc_q.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                beat_q.push_back({bus.out_last, bus.out_data});
                beat_cyc_q.push_back(cyc);
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        iss_addr_q.delete();
        iss_cyc_q.delete();
        beat_q.delete();
        beat_cyc_q.delete();
    endtask

    task automatic send_req(input logic [ABITS-1:0] addr, input logic [LBITS-1:0] len,
                            output int acc_cyc);
        bit done;
        done          = 1'b0;
        acc_cyc       = -1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.req_ready) begin
                acc_cyc = cyc;
                done    = 1'b1;
            end
            step();
        end
        bus.req_valid = 1'b0;
        if (!done) check("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input bit rand_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (!busy) done = 1'b1;
            else begin
                if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        bus.out_ready = 1'b1;
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Reference: beat i of a burst is mem[(addr+i) mod 2^ABITS], last only on i==len.
    task automatic verify_burst(input string tag, input logic [ABITS-1:0] addr,
                                input int len, input int boff);
        logic [ABITS-1:0] a;
        fifo_entry_t      e;
        for (int i = 0; i <= len; i++) begin
            a      = addr + ABITS'(i);
            e.data = mem_word(a);
            e.last = (i == len);
            if (boff + i < beat_q.size()) begin
                check({tag, "_data"}, 32'(beat_q[boff+i].data), 32'(e.data));
                check({tag, "_last"}, 32'(beat_q[boff+i].last), 32'(e.last));
            end
            if (boff + i < iss_addr_q.size())
                check({tag, "_a1"}, 32'(iss_addr_q[boff+i]), 32'(a));
        end
    endtask

    typedef struct {
        logic [ABITS-1:0] addr;
        logic [LBITS-1:0] len;
        int               exp_beats;
        logic [ABITS-1:0] exp_first_a1;
        logic [ABITS-1:0] exp_last_a1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int               acc;
        int               acc2;
        int               n_iss;
        int               busy_low;
        int               nb;
        logic [ABITS-1:0] raddr;
        logic [LBITS-1:0] rlen;

        vecs[0] = '{addr: 20'h03FFE, len: 20'd7,  exp_beats: 8,  exp_first_a1: 20'h03FFE, exp_last_a1: 20'h04005};
        vecs[1] = '{addr: 20'hFFFFE, len: 20'd3,  exp_beats: 4,  exp_first_a1: 20'hFFFFE, exp_last_a1: 20'h00001};
        vecs[2] = '{addr: 20'h12345, len: 20'd0,  exp_beats: 1,  exp_first_a1: 20'h12345, exp_last_a1: 20'h12345};
        vecs[3] = '{addr: 20'h00000, len: 20'd15, exp_beats: 16, exp_first_a1: 20'h00000, exp_last_a1: 20'h0000F};
        vecs[4] = '{addr: 20'h7FFFF, len: 20'd1,  exp_beats: 2,  exp_first_a1: 20'h7FFFF, exp_last_a1: 20'h80000};

        RST           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_ce1",       32'(bus.CE1),       32'd0);
        check("rst_a1",        32'(bus.A1),        32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        RST = 1'b0;
        step();

        // Single beat: latency and busy drop.
        clear_mon();
        send_req(20'h00010, 20'd0, acc);
        busy_low = -1;
        for (int i = 0; i < 20 && busy_low < 0; i++) begin
            if (!busy) busy_low = cyc;
            else step();
        end
        $display("burst single addr=00010 len=0 beats=%0d", beat_q.size());
        check("single_issues", 32'(iss_addr_q.size()), 32'd1);
        check("single_beats",  32'(beat_q.size()),     32'd1);
        if (iss_cyc_q.size() > 0)  check("single_ce1_lat",  32'(iss_cyc_q[0] - acc),  32'd1);
        if (beat_cyc_q.size() > 0) check("single_beat_lat", 32'(beat_cyc_q[0] - acc), 32'd3);
        check("single_busy_low", 32'(busy_low - acc), 32'd4);
        verify_burst("single", 20'h00010, 0, 0);

        // Table: streaming bursts with out_ready held high.
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            bus.out_ready = 1'b1;
            send_req(vecs[v].addr, vecs[v].len, acc);
            wait_idle(1'b0);
            nb = beat_q.size();
            $display("burst vec%0d addr=%05h len=%0d beats=%0d", v, vecs[v].addr, vecs[v].len, nb);
            check("vec_beats",  32'(nb),                32'(vecs[v].exp_beats));
            check("vec_issues", 32'(iss_addr_q.size()), 32'(vecs[v].exp_beats));
            if (iss_addr_q.size() > 0) begin
                check("vec_first_a1",  32'(iss_addr_q[0]),                   32'(vecs[v].exp_first_a1));
                check("vec_last_a1",   32'(iss_addr_q[iss_addr_q.size()-1]), 32'(vecs[v].exp_last_a1));
                check("vec_issue_gap", 32'(iss_cyc_q[iss_cyc_q.size()-1] - iss_cyc_q[0]),
                      32'(vecs[v].exp_beats - 1));
            end
            if (nb > 0) begin
                check("vec_beat_gap", 32'(beat_cyc_q[nb-1] - beat_cyc_q[0]), 32'(vecs[v].exp_beats - 1));
                check("vec_beat_lat", 32'(beat_cyc_q[0] - acc), 32'd3);
            end
            verify_burst("vec", vecs[v].addr, int'(vecs[v].len), 0);
        end

        // Backpressure: only DEPTH reads may be outstanding.
        clear_mon();
        bus.out_ready = 1'b0;
        send_req(20'h00200, 20'd15, acc);
        repeat (20) step();
        $display("burst backpressure addr=00200 len=15 issued_while_stalled=%0d", iss_addr_q.size());
        check("bp_issues",    32'(iss_addr_q.size()), 32'(DEPTH));
        check("bp_ce1_off",   32'(bus.CE1),           32'd0);
        check("bp_no_beats",  32'(beat_q.size()),     32'd0);
        check("bp_out_valid", 32'(bus.out_valid),     32'd1);
        check("bp_head_data", 32'(bus.out_data),      32'(mem_word(20'h00200)));
        check("bp_head_last", 32'(bus.out_last),      32'd0);
        bus.out_ready = 1'b1;
        wait_idle(1'b0);
        check("bp_beats", 32'(beat_q.size()), 32'd16);
        verify_burst("bp", 20'h00200, 15, 0);

        // Back-to-back bursts with the request held valid.
        clear_mon();
        send_req(20'h00500, 20'd2, acc);
        send_req(20'h00600, 20'd0, acc2);
        wait_idle(1'b0);
        $display("burst b2b addr=00500/00600 len=2/0 beats=%0d", beat_q.size());
        check("b2b_beats", 32'(beat_q.size()), 32'd4);
        if (iss_cyc_q.size() > 2) check("b2b_accept", 32'(acc2 - iss_cyc_q[2]), 32'd1);
        verify_burst("b2b0", 20'h00500, 2, 0);
        verify_burst("b2b1", 20'h00600, 0, 3);

        // Reset in the cycle of the third issue.
        clear_mon();
        send_req(20'h00700, 20'd9, acc);
        n_iss = 0;
        for (int i = 0; i < 50 && n_iss < 3; i++) begin
            if (bus.CE1) n_iss++;
            if (n_iss < 3) step();
        end
        check("mrst_reached", 32'(n_iss), 32'd3);
        RST = 1'b1;
        #1;
        check("mrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mrst_ce1",       32'(bus.CE1),       32'd0);
        check("mrst_a1",        32'(bus.A1),        32'd0);
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_out_data",  32'(bus.out_data),  32'd0);
        check("mrst_out_last",  32'(bus.out_last),  32'd0);
        check("mrst_busy",      32'(busy),          32'd0);
        step();
        step();
        RST = 1'b0;
        step();
        clear_mon();
        send_req(20'h00800, 20'd0, acc);
        wait_idle(1'b0);
        $display("burst post_reset addr=00800 len=0 beats=%0d", beat_q.size());
        check("mrst_beats",  32'(beat_q.size()),     32'd1);
        check("mrst_issues", 32'(iss_addr_q.size()), 32'd1);
        verify_burst("mrst", 20'h00800, 0, 0);

        // Randomized bursts with random backpressure.
        for (int r = 0; r < 25; r++) begin
            clear_mon();
            raddr         = ABITS'($urandom);
            rlen          = LBITS'($urandom_range(0, 12));
            bus.out_ready = 1'($urandom_range(0, 1));
            send_req(raddr, rlen, acc);
            wait_idle(1'b1);
            $display("burst rand%0d addr=%05h len=%0d beats=%0d", r, raddr, rlen, beat_q.size());
            check("rand_beats",  32'(beat_q.size()),     32'(rlen) + 32'd1);
            check("rand_issues", 32'(iss_addr_q.size()), 32'(rlen) + 32'd1);
            verify_burst("rand", raddr, int'(rlen), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
